// File: rtl/scoreboard_register_file.sv
// Register file with a per-entry busy scoreboard for in-flight writebacks.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data/busy onto the read ports.
module scoreboard_register_file #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 4,
    parameter int ZERO_REG   = 0
) (
    input  logic                  CPU_CLOCK,
    input  logic                  CLEAR,
    input  logic [ADDR_WIDTH-1:0] READ_REG_1,
    input  logic [ADDR_WIDTH-1:0] READ_REG_2,
    input  logic [ADDR_WIDTH-1:0] WRITE_REG,
    input  logic [DATA_WIDTH-1:0] WRITE_DATA,
    input  logic                  REG_WRITE_ENABLE,
    input  logic                  RESERVE_ENABLE,
    input  logic [ADDR_WIDTH-1:0] RESERVE_REG,
    output logic [DATA_WIDTH-1:0] READ_DATA_1,
    output logic [DATA_WIDTH-1:0] READ_DATA_2,
    output logic                  READ_BUSY_1,
    output logic                  READ_BUSY_2,
    output logic [ADDR_WIDTH:0]   BUSY_COUNT
);

    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
    logic [DEPTH-1:0]                 busy;
    logic [DEPTH-1:0]                 busy_next;
    logic [ADDR_WIDTH:0]              busy_count;
    logic [ADDR_WIDTH:0]              count_inc;
    logic [ADDR_WIDTH:0]              count_dec;

    logic write_ok;
    logic reserve_ok;
    logic set_new;
    logic clr_old;

    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_data [2];
    logic [1:0]            rd_busy;

    // Entry 0 is hardwired when ZERO_REG is set, so both strobes are masked there.
    assign write_ok   = REG_WRITE_ENABLE && !(ZERO_EN && (WRITE_REG == '0));
    assign reserve_ok = RESERVE_ENABLE && !(ZERO_EN && (RESERVE_REG == '0));

    // A same-register reserve keeps the bit set, so no decrement in that case.
    assign set_new = reserve_ok && !busy[RESERVE_REG];
    assign clr_old = write_ok && busy[WRITE_REG] && !(reserve_ok && (RESERVE_REG == WRITE_REG));

    assign count_inc = {{ADDR_WIDTH{1'b0}}, set_new};
    assign count_dec = {{ADDR_WIDTH{1'b0}}, clr_old};

    always_comb begin
        busy_next = busy;
        if (write_ok) begin
            busy_next[WRITE_REG] = 1'b0;
        end
        if (reserve_ok) begin
            busy_next[RESERVE_REG] = 1'b1;
        end
    end

    always_ff @(posedge CPU_CLOCK) begin
        if (CLEAR) begin
            regs       <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (write_ok) begin
                regs[WRITE_REG] <= WRITE_DATA;
            end
            busy       <= busy_next;
            busy_count <= busy_count + count_inc - count_dec;
        end
    end

    assign rd_addr[0] = READ_REG_1;
    assign rd_addr[1] = READ_REG_2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (write_ok && (WRITE_REG == rd_addr[p])) begin
                rd_data[p] = WRITE_DATA;
                rd_busy[p] = reserve_ok && (RESERVE_REG == rd_addr[p]);
            end
`endif
            if (ZERO_EN && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign READ_DATA_1 = rd_data[0];
    assign READ_DATA_2 = rd_data[1];
    assign READ_BUSY_1 = rd_busy[0];
    assign READ_BUSY_2 = rd_busy[1];
    assign BUSY_COUNT  = busy_count;

endmodule
